// File: rtl/musa_pkg.sv
// musa_pkg: shared MUSA instruction field layout and immediate-extension encodings
package musa_pkg;
  localparam int INSTR_W  = 32;
  localparam int OPCODE_W = 6;
  localparam int REG_W    = 5;
  localparam int JT_W     = 26;
  localparam int IMM_W    = 16;
  localparam int OP_LSB   = 26;
  localparam int RS_LSB   = 21;
  localparam int RT_LSB   = 16;
  localparam int RD_LSB   = 11;
  localparam int IMM_LSB  = 0;
  localparam int JT_LSB   = 0;
  typedef enum logic {EXT_SIGN = 1'b0, EXT_ZERO = 1'b1} ext_mode_e;
endpackage

// File: rtl/regfile_2r1w.sv
// regfile_2r1w: two combinational read ports, one write port, with write-back bypass
module regfile_2r1w #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
)(
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] ra_addr,
  input  logic [ADDR_W-1:0] rb_addr,
  output logic [DATA_W-1:0] ra_data,
  output logic [DATA_W-1:0] rb_data,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd
);
  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic              wr_ok;
  assign wr_ok = we && !(ZERO_REG != 0 && wa == '0);
  always_ff @(posedge clk or negedge rst)
    if (!rst) mem <= '{default: '0};
    else if (wr_ok) mem[wa] <= wd;
  // bypass first so a same-cycle write-back is visible to the reader
  assign ra_data = (wr_ok && wa == ra_addr) ? wd : (ZERO_REG != 0 && ra_addr == '0) ? '0 : mem[ra_addr];
  assign rb_data = (wr_ok && wa == rb_addr) ? wd : (ZERO_REG != 0 && rb_addr == '0) ? '0 : mem[rb_addr];
endmodule

// File: rtl/id_stage_pipe.sv
// id_stage_pipe: MUSA decode stage with register file, load-use stall and valid/ready ID/EX register
module id_stage_pipe
  import musa_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 5,
  parameter int CTRL_W      = 12,
  parameter int ZERO_REG    = 1,
  parameter int STALL_CNT_W = 16
)(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [INSTR_W-1:0]     instruction,
  output logic [OPCODE_W-1:0]    opcode,
  input  logic [CTRL_W-1:0]      ctrl_in,
  input  logic                   uses_rt,
  input  logic                   reg_dst,
  input  logic                   ext_mode,
  input  logic                   flush,
  input  logic                   wb_en,
  input  logic [ADDR_W-1:0]      wb_addr,
  input  logic [DATA_W-1:0]      wb_data,
  input  logic                   ex_valid,
  input  logic                   ex_mem_read,
  input  logic [ADDR_W-1:0]      ex_rd,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [CTRL_W-1:0]      out_ctrl,
  output logic [DATA_W-1:0]      out_rs_data,
  output logic [DATA_W-1:0]      out_rt_data,
  output logic [DATA_W-1:0]      out_imm,
  output logic [ADDR_W-1:0]      out_dst,
  output logic [JT_W-1:0]        out_jtarget,
  output logic [STALL_CNT_W-1:0] stall_cnt
);
  logic [ADDR_W-1:0] rs, rt, rd;
  logic [DATA_W-1:0] rs_data, rt_data, imm_ext;
  logic [IMM_W-1:0]  imm;
  logic              hazard, slot_free, accept;
  assign opcode = instruction[OP_LSB +: OPCODE_W];
  assign rs     = ADDR_W'(instruction[RS_LSB +: REG_W]);
  assign rt     = ADDR_W'(instruction[RT_LSB +: REG_W]);
  assign rd     = ADDR_W'(instruction[RD_LSB +: REG_W]);
  assign imm    = instruction[IMM_LSB +: IMM_W];
  assign imm_ext = {{(DATA_W-IMM_W){ext_mode == EXT_SIGN && imm[IMM_W-1]}}, imm};
  regfile_2r1w #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG)) u_rf (
    .clk(clk), .rst(rst),
    .ra_addr(rs), .rb_addr(rt), .ra_data(rs_data), .rb_data(rt_data),
    .we(wb_en), .wa(wb_addr), .wd(wb_data)
  );
  // a load into the hard-wired zero register never produces a real dependency
  assign hazard = in_valid && ex_valid && ex_mem_read && (ex_rd != '0 || ZERO_REG == 0)
                  && (ex_rd == rs || (uses_rt && ex_rd == rt));
  assign slot_free = !out_valid || out_ready;
  assign in_ready  = slot_free && !hazard && !flush;
  assign accept    = in_valid && in_ready;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      out_valid   <= 1'b0;
      out_ctrl    <= '0;
      out_rs_data <= '0;
      out_rt_data <= '0;
      out_imm     <= '0;
      out_dst     <= '0;
      out_jtarget <= '0;
      stall_cnt   <= '0;
    end else begin
      out_valid <= !flush && (slot_free ? accept : out_valid);
      if (accept) begin
        out_ctrl    <= ctrl_in;
        out_rs_data <= rs_data;
        out_rt_data <= rt_data;
        out_imm     <= imm_ext;
        out_dst     <= reg_dst ? rd : rt;
        out_jtarget <= instruction[JT_LSB +: JT_W];
      end
      if (hazard && slot_free && stall_cnt != '1) stall_cnt <= stall_cnt + STALL_CNT_W'(1);
    end
endmodule

// File: tb/tb_id_stage_pipe.sv
// tb_id_stage_pipe: directed and randomized checks of id_stage_pipe against a behavioural model
module tb_id_stage_pipe;
  logic        clk, rst;
  logic        in_valid, in_ready, uses_rt, reg_dst, ext_mode, flush;
  logic [31:0] instruction;
  logic [5:0]  opcode;
  logic [11:0] ctrl_in, out_ctrl;
  logic        wb_en, ex_valid, ex_mem_read, out_valid, out_ready;
  logic [4:0]  wb_addr, ex_rd, out_dst;
  logic [31:0] wb_data, out_rs_data, out_rt_data, out_imm;
  logic [25:0] out_jtarget;
  logic [15:0] stall_cnt;

  id_stage_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .instruction(instruction),
    .opcode(opcode), .ctrl_in(ctrl_in), .uses_rt(uses_rt), .reg_dst(reg_dst), .ext_mode(ext_mode),
    .flush(flush), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .ex_valid(ex_valid),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .out_valid(out_valid), .out_ready(out_ready),
    .out_ctrl(out_ctrl), .out_rs_data(out_rs_data), .out_rt_data(out_rt_data), .out_imm(out_imm),
    .out_dst(out_dst), .out_jtarget(out_jtarget), .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0, checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // reference model: architectural registers plus the bundle EX should see
  logic [31:0] m_rf [32];
  logic        m_valid;
  logic [11:0] m_ctrl;
  logic [31:0] m_a, m_b, m_imm;
  logic [4:0]  m_dst;
  logic [25:0] m_jt;
  int          m_stall;

  function automatic void m_reset();
    for (int i = 0; i < 32; i++) m_rf[i] = 0;
    m_valid = 0; m_ctrl = 0; m_a = 0; m_b = 0; m_imm = 0; m_dst = 0; m_jt = 0; m_stall = 0;
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 0) return 0;
    if (wb_en && wb_addr == a) return wb_data;
    return m_rf[a];
  endfunction

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] s, input logic [4:0] t, input logic [15:0] im);
    return {op, s, t, im};
  endfunction

  task automatic step();
    logic [4:0] s, t;
    logic hz, sf, rdy, acc;
    #1;
    s = instruction[25:21];
    t = instruction[20:16];
    hz = in_valid && ex_valid && ex_mem_read && ex_rd != 0 && (ex_rd == s || (uses_rt && ex_rd == t));
    sf = !m_valid || out_ready;
    rdy = sf && !hz && !flush;
    acc = in_valid && rdy;
    check("in_ready", {31'b0, in_ready}, {31'b0, rdy});
    check("opcode", {26'b0, opcode}, {26'b0, instruction[31:26]});
    @(posedge clk);
    if (acc) begin
      m_ctrl = ctrl_in;
      m_a    = m_read(s);
      m_b    = m_read(t);
      m_imm  = ext_mode ? {16'h0, instruction[15:0]} : {{16{instruction[15]}}, instruction[15:0]};
      m_dst  = reg_dst ? instruction[15:11] : t;
      m_jt   = instruction[25:0];
    end
    if (flush) m_valid = 0;
    else if (acc) m_valid = 1;
    else if (sf) m_valid = 0;
    if (hz && sf && m_stall < 65535) m_stall++;
    if (wb_en && wb_addr != 0) m_rf[wb_addr] = wb_data;
    @(negedge clk);
    check("out_valid", {31'b0, out_valid}, {31'b0, m_valid});
    check("out_ctrl", {20'b0, out_ctrl}, {20'b0, m_ctrl});
    check("out_rs_data", out_rs_data, m_a);
    check("out_rt_data", out_rt_data, m_b);
    check("out_imm", out_imm, m_imm);
    check("out_dst", {27'b0, out_dst}, {27'b0, m_dst});
    check("out_jtarget", {6'b0, out_jtarget}, {6'b0, m_jt});
    check("stall_cnt", {16'b0, stall_cnt}, m_stall);
  endtask

  initial begin
    rst = 0; in_valid = 0; instruction = 0; ctrl_in = 0; uses_rt = 0; reg_dst = 0; ext_mode = 0;
    flush = 0; wb_en = 0; wb_addr = 0; wb_data = 0; ex_valid = 0; ex_mem_read = 0; ex_rd = 0; out_ready = 1;
    m_reset();
    repeat (2) @(negedge clk);
    check("reset out_valid", {31'b0, out_valid}, 0);
    check("reset stall_cnt", {16'b0, stall_cnt}, 0);
    check("reset out_rs_data", out_rs_data, 0);
    rst = 1;
    // write-back then read through a later instruction
    wb_en = 1; wb_addr = 3; wb_data = 32'h12345678;
    step();
    wb_en = 0; in_valid = 1; ctrl_in = 12'hA5C; instruction = mk(6'h08, 5'd3, 5'd0, 16'h0010);
    step();
    check("rf read r3", out_rs_data, 32'h12345678);
    // same-cycle bypass and the zero register
    wb_en = 1; wb_addr = 7; wb_data = 32'hDEADBEEF; uses_rt = 1; instruction = mk(6'h00, 5'd0, 5'd7, 16'h0);
    step();
    check("bypass r7", out_rt_data, 32'hDEADBEEF);
    wb_addr = 0; wb_data = 32'hFFFFFFFF; instruction = mk(6'h00, 5'd0, 5'd0, 16'h0);
    step();
    check("zero reg rs", out_rs_data, 0);
    check("zero reg rt", out_rt_data, 0);
    // load-use stall
    wb_en = 0; uses_rt = 0; ex_valid = 1; ex_mem_read = 1; ex_rd = 5; instruction = mk(6'h23, 5'd5, 5'd1, 16'h0004);
    step();
    check("load-use bubble", {31'b0, out_valid}, 0);
    check("load-use stall_cnt", {16'b0, stall_cnt}, 1);
    ex_valid = 0;
    step();
    check("after stall accepted", {31'b0, out_valid}, 1);
    // backpressure holds the bundle and blocks intake
    out_ready = 0; instruction = mk(6'h02, 5'd1, 5'd2, 16'h1234);
    repeat (3) begin
      step();
      check("hold out_jtarget", {6'b0, out_jtarget}, {6'b0, 5'd5, 5'd1, 16'h0004});
    end
    out_ready = 1;
    step();
    check("accept after release", {6'b0, out_jtarget}, {6'b0, 26'h0221234});
    // immediate extension and destination select
    instruction = mk(6'h09, 5'd1, 5'd4, 16'h8001); ext_mode = 0;
    step();
    check("sign ext", out_imm, 32'hFFFF8001);
    ext_mode = 1;
    step();
    check("zero ext", out_imm, 32'h00008001);
    instruction = mk(6'h00, 5'd1, 5'd4, 16'h4800); reg_dst = 1;
    step();
    check("dst rd", {27'b0, out_dst}, 9);
    reg_dst = 0;
    step();
    check("dst rt", {27'b0, out_dst}, 4);
    // flush kills the bundle and leaves the input unconsumed
    flush = 1; instruction = mk(6'h04, 5'd2, 5'd3, 16'h0077);
    step();
    check("flush out_valid", {31'b0, out_valid}, 0);
    flush = 0;
    step();
    check("post-flush accept", {31'b0, out_valid}, 1);
    // randomized traffic with frequent bypass and hazard collisions
    for (int n = 0; n < 500; n++) begin
      in_valid = $urandom_range(0, 3) != 0;
      instruction = $urandom;
      instruction[25:21] = 5'($urandom_range(0, 7));
      instruction[20:16] = 5'($urandom_range(0, 7));
      ctrl_in = 12'($urandom);
      uses_rt = 1'($urandom); reg_dst = 1'($urandom); ext_mode = 1'($urandom);
      flush = $urandom_range(0, 9) == 0;
      wb_en = 1'($urandom); wb_addr = 5'($urandom_range(0, 7)); wb_data = $urandom;
      ex_valid = 1'($urandom); ex_mem_read = 1'($urandom); ex_rd = 5'($urandom_range(0, 7));
      out_ready = $urandom_range(0, 3) != 0;
      step();
    end
    // asynchronous reset in the middle of a cycle
    @(posedge clk);
    #2 rst = 0;
    #1;
    check("async reset out_valid", {31'b0, out_valid}, 0);
    check("async reset stall_cnt", {16'b0, stall_cnt}, 0);
    m_reset();
    @(negedge clk);
    rst = 1; in_valid = 1; flush = 0; wb_en = 0; ex_valid = 0; out_ready = 1; uses_rt = 1;
    instruction = mk(6'h08, 5'd3, 5'd7, 16'h0);
    step();
    check("regs lost rs", out_rs_data, 0);
    check("regs lost rt", out_rt_data, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/id_stage_pipe.md
Name: id_stage_pipe

Overview:
Parametrised instruction-decode stage for the MUSA core. It contains:
- the architectural register file;
- write-back bypass;
- load-use hazard detection;
- immediate extension;
- a valid/ready ID/EX pipeline register.

The external unit_control decodes `opcode` combinationally and returns a control word. This block registers that word alongside the operands, so EX sees one aligned bundle.

Parameters:
- DATA_W, 32: register/operand width
- ADDR_W, 5: register index width; register count is 2**ADDR_W
- CTRL_W, 12: width of control word from unit_control
- ZERO_REG, 1: 1 means register 0 reads zero and ignores writes
- STALL_CNT_W, 16: width of saturating hazard-stall counter

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- in_valid  in  1  instruction valid from IF
- in_ready  out  1  ID can accept instruction
- instruction  in  32  fields: opcode[31:26], rs[25:21], rt[20:16], rd[15:11], imm[15:0], jtarget[25:0]
- opcode  out  6  instruction[31:26], to unit_control (combinational)
- ctrl_in  in  CTRL_W  control word from unit_control
- uses_rt  in  1  instruction reads rt (from unit_control)
- reg_dst  in  1  1 selects rd as destination, 0 selects rt
- ext_mode  in  1  0 sign-extends imm, 1 zero-extends imm
- flush  in  1  synchronous kill of ID/EX contents and current input
- wb_en  in  1  write-back enable
- wb_addr  in  ADDR_W  write-back register
- wb_data  in  DATA_W  write-back data (ALU or memory, muxed upstream)
- ex_valid  in  1  EX stage holds a valid instruction
- ex_mem_read  in  1  EX instruction is a load
- ex_rd  in  ADDR_W  EX destination register
- out_valid  out  1  ID/EX bundle valid
- out_ready  in  1  EX accepts bundle
- out_ctrl  out  CTRL_W  registered ctrl_in
- out_rs_data  out  DATA_W  registered operand A
- out_rt_data  out  DATA_W  registered operand B
- out_imm  out  DATA_W  registered extended immediate
- out_dst  out  ADDR_W  registered destination index
- out_jtarget  out  26  registered jump field
- stall_cnt  out  STALL_CNT_W  saturating count of hazard-stall cycles

Behaviour:
- Reset (rst=0, asynchronous):
  - all registers zero;
  - out_valid=0, stall_cnt=0, all out_* zero.
- Index extraction: rs and rt come from instruction[25:21] and [20:16]. Index widths above 5 bits zero-extend the 5-bit field.
- Register file:
  - two combinational read ports, one synchronous write port;
  - write occurs at posedge when wb_en=1, except address 0 when ZERO_REG=1;
  - reading address 0 returns 0 when ZERO_REG=1.
- Bypass: if wb_en=1, wb_addr equals the read index, and that index is writable, the read returns wb_data in the same cycle. The write-back value is never lost to a read/write collision.
- hazard = in_valid & ex_valid & ex_mem_read & (ex_rd≠0 or ZERO_REG=0) & (ex_rd==rs | (uses_rt & ex_rd==rt)).
- slot_free = !out_valid | out_ready.
- in_ready = slot_free & !hazard & !flush.
- Accept (in_valid & in_ready): next cycle out_valid=1 and all out_* load.
  - out_imm = sign- or zero-extended imm, per ext_mode.
  - out_dst = reg_dst ? rd : rt.
  - Latency is 1 cycle from accept to out_valid.
- Hold: if out_valid=1 and out_ready=0, all out_* stay stable. Operands do not re-read the register file.
- Hazard with slot_free: a bubble is inserted (out_valid=0 next cycle) and the instruction stays at the input.
  - stall_cnt increments once per hazard cycle and saturates at all-ones.
- Hazard without slot_free: hold takes precedence; no bubble is inserted.
- Flush:
  - has highest priority; next cycle out_valid=0;
  - the input in that cycle is not accepted;
  - write-back and stall_cnt updates still occur.
- Payload registers: update only on accept (no clear on bubble or flush); only out_valid clears.
- Reset mid-operation: immediate return to reset state. Register contents are lost.

Decomposition:
- Shared package musa_pkg:
  - opcode/field bit positions;
  - OPCODE_W=6, JT_W=26, IMM_W=16;
  - ext_mode encodings EXT_SIGN=0, EXT_ZERO=1.
- Sub-module regfile_2r1w, parametrised by DATA_W, ADDR_W, ZERO_REG. It includes the bypass logic.
- Hazard logic, extension and the pipeline register stay in the top level.

Test Plan:
- Reset, then write-back wb_en=1 wb_addr=3 wb_data=0x12345678. Next, instruction with rs=3 → out_rs_data=0x12345678 one cycle after accept.
- Same-cycle bypass: wb to r7=0xDEADBEEF while accepting an instruction with rt=7, uses_rt=1 → out_rt_data=0xDEADBEEF. Also write r0=0xFFFFFFFF and read r0 → 0.
- Load-use: ex_valid=1, ex_mem_read=1, ex_rd=5, instruction rs=5 → in_ready=0 and one bubble (out_valid=0), stall_cnt=1. Drop ex_valid → accepted next cycle.
- Backpressure: out_ready=0 for 3 cycles with out_valid=1 → out_* constant and in_ready=0. On the cycle out_ready=1, the next instruction is accepted.
- Immediate and destination: imm=0x8001, ext_mode=0 → out_imm=0xFFFF8001. ext_mode=1 → 0x00008001. reg_dst=1, rd=9 → out_dst=9; reg_dst=0, rt=4 → out_dst=4.
- Flush with in_valid=1 and out_valid=1 → next cycle out_valid=0 and the instruction is not consumed. Assert rst low mid-stream → out_valid=0 and stall_cnt=0 immediately.
